// File: rtl/dvs_event_streamer.sv
// dvs_event_streamer: buffers AER events in a FIFO and serializes each record MSB byte first.
// Define DVS_EVENT_DROP_CNT_EN to add the saturating drop_count output.
`ifndef DVS_X_ADDR_BITS
`define DVS_X_ADDR_BITS 8
`endif
`ifndef DVS_Y_ADDR_BITS
`define DVS_Y_ADDR_BITS 7
`endif
`ifndef TIMESTAMP_US_BITS
`define TIMESTAMP_US_BITS 16
`endif

module dvs_event_streamer #(
   parameter int X_BITS     = `DVS_X_ADDR_BITS,
   parameter int Y_BITS     = `DVS_Y_ADDR_BITS,
   parameter int TS_BITS    = `TIMESTAMP_US_BITS,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [X_BITS-1:0]             event_x,
   input  logic [Y_BITS-1:0]             event_y,
   input  logic [TS_BITS-1:0]            event_timestamp,
   input  logic                          event_polarity,
   input  logic                          new_event,
   output logic [7:0]                    tx_data,
   output logic                          tx_valid,
   input  logic                          tx_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow,
   input  logic                          overflow_clr
`ifdef DVS_EVENT_DROP_CNT_EN
   ,
   output logic [15:0]                   drop_count
`endif
);
   localparam int REC_BITS = 1 + X_BITS + Y_BITS + TS_BITS;
   localparam int NBYTES   = (REC_BITS + 7) / 8;
   localparam int W_BITS   = NBYTES * 8;
   localparam int PTR_W    = $clog2(FIFO_DEPTH);
   localparam int CNT_W    = PTR_W + 1;
   localparam int IDX_W    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [CNT_W-1:0] FULL = CNT_W'(FIFO_DEPTH);
   localparam logic [IDX_W-1:0] LAST = IDX_W'(NBYTES - 1);

   typedef enum logic {IDLE, SEND} state_t;
   state_t r_state, w_next;

   logic [W_BITS-1:0] r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  r_wptr, r_rptr;
   logic [CNT_W-1:0]  r_count;
   logic [W_BITS-1:0] r_shift;
   logic [IDX_W-1:0]  r_idx;
   logic              r_overflow;
   logic [W_BITS-1:0] w_rec;
   logic              w_full, w_push, w_drop, w_pop, w_hs;

   always_comb begin
      w_rec = '0;
      w_rec[REC_BITS-1:0] = {event_polarity, event_x, event_y, event_timestamp};
   end

   // Fullness is judged on the pre-edge count, so a same-edge pop never rescues a push.
   assign w_full = (r_count == FULL);
   assign w_push = new_event && !w_full;
   assign w_drop = new_event && w_full;
   assign w_hs   = (r_state == SEND) && tx_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      w_pop  = 1'b0;
      case (r_state)
         IDLE: begin
            if (r_count != '0) begin
               w_pop  = 1'b1;
               w_next = SEND;
            end
         end
         SEND: begin
            if (tx_ready && (r_idx == LAST)) begin
               if (r_count != '0) w_pop  = 1'b1;
               else               w_next = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         if (w_push && !w_pop)      r_count <= r_count + 1'b1;
         else if (!w_push && w_pop) r_count <= r_count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= w_rec;
   end

   // The current byte always sits at the top of r_shift; r_idx only tracks the record end.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shift <= '0;
         r_idx   <= '0;
      end else if (w_pop) begin
         r_shift <= r_mem[r_rptr];
         r_idx   <= '0;
      end else if (w_hs) begin
         r_shift <= r_shift << 8;
         r_idx   <= r_idx + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)            r_overflow <= 1'b0;
      else if (w_drop)       r_overflow <= 1'b1;
      else if (overflow_clr) r_overflow <= 1'b0;
   end

`ifdef DVS_EVENT_DROP_CNT_EN
   logic [15:0] r_drop_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                          r_drop_cnt <= '0;
      else if (overflow_clr)               r_drop_cnt <= w_drop ? 16'd1 : 16'd0;
      else if (w_drop && r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 16'd1;
   end

   assign drop_count = r_drop_cnt;
`endif

   assign tx_valid   = (r_state == SEND);
   assign tx_data    = (r_state == SEND) ? r_shift[W_BITS-1 -: 8] : '0;
   assign fifo_count = r_count;
   assign overflow   = r_overflow;

endmodule

// File: tb/tb_dvs_event_streamer.sv
// Directed self-checking bench for dvs_event_streamer (X=8, Y=7, TS=16, 4-byte records, depth 16).
module tb_dvs_event_streamer;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  event_x = '0;
   logic [6:0]  event_y = '0;
   logic [15:0] event_timestamp = '0;
   logic        event_polarity = 1'b0;
   logic        new_event = 1'b0;
   logic        tx_ready = 1'b0;
   logic        overflow_clr = 1'b0;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic [4:0]  fifo_count;
   logic        overflow;
`ifdef DVS_EVENT_DROP_CNT_EN
   logic [15:0] drop_count;
`endif

   int n_pass = 0;
   int n_total = 0;

   logic [7:0]  burst_exp [12] = '{8'h00, 8'h00, 8'h00, 8'h01,
                                   8'hFF, 8'hFF, 8'hFF, 8'hFF,
                                   8'h40, 8'h01, 8'hA5, 8'h5A};
   logic [7:0]  got_b [$];
   logic [31:0] got_w [$];

   dvs_event_streamer #(
      .X_BITS(8), .Y_BITS(7), .TS_BITS(16), .FIFO_DEPTH(16)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .event_x(event_x),
      .event_y(event_y),
      .event_timestamp(event_timestamp),
      .event_polarity(event_polarity),
      .new_event(new_event),
      .tx_data(tx_data),
      .tx_valid(tx_valid),
      .tx_ready(tx_ready),
      .fifo_count(fifo_count),
`ifdef DVS_EVENT_DROP_CNT_EN
      .drop_count(drop_count),
`endif
      .overflow(overflow),
      .overflow_clr(overflow_clr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_ev(input logic [7:0] x, input logic [6:0] y, input logic [15:0] ts,
                         input logic p);
      event_x         = x;
      event_y         = y;
      event_timestamp = ts;
      event_polarity  = p;
      new_event       = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int first, last, peak, nb, cyc;
      logic [31:0] acc, expw;

      // reset state
      #1;
      chk("rst_valid", tx_valid, 0);
      chk("rst_data", tx_data, 0);
      chk("rst_count", fifo_count, 0);
      chk("rst_ovf", overflow, 0);
`ifdef DVS_EVENT_DROP_CNT_EN
      chk("rst_drop", drop_count, 0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      tx_ready = 1'b1;

      // single event, latency and byte order
      set_ev(8'hA5, 7'h12, 16'h1234, 1'b1);
      tick();
      new_event = 1'b0;
      chk("lat_e0_valid", tx_valid, 0);
      chk("lat_e0_count", fifo_count, 1);
      tick();
      chk("lat_e1_valid", tx_valid, 1);
      chk("single_b0", tx_data, 8'hD2);
      chk("single_cnt", fifo_count, 0);
      tick(); chk("single_b1", tx_data, 8'h92);
      tick(); chk("single_b2", tx_data, 8'h12);
      tick(); chk("single_b3", tx_data, 8'h34);
      tick(); chk("single_idle", tx_valid, 0);

      // backpressure mid-record
      set_ev(8'h3C, 7'h55, 16'hBEEF, 1'b0);
      tick();
      new_event = 1'b0;
      tick(); chk("bp_b0", tx_data, 8'h1E);
      tick(); chk("bp_b1", tx_data, 8'h55);
      tx_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_hold_data", tx_data, 8'h55);
         chk("bp_hold_valid", tx_valid, 1);
      end
      tx_ready = 1'b1;
      tick(); chk("bp_b2", tx_data, 8'hBE);
      tick(); chk("bp_b3", tx_data, 8'hEF);
      tick(); chk("bp_idle", tx_valid, 0);

      // burst of 3 strobes on consecutive cycles
      first = -1; last = -1; peak = 0;
      for (int i = 0; i < 20; i++) begin
         if (tx_valid) begin
            got_b.push_back(tx_data);
            if (first < 0) first = i;
            last = i;
         end
         if (int'(fifo_count) > peak) peak = int'(fifo_count);
         case (i)
            0: set_ev(8'h00, 7'h00, 16'h0001, 1'b0);
            1: set_ev(8'hFF, 7'h7F, 16'hFFFF, 1'b1);
            2: set_ev(8'h80, 7'h01, 16'hA55A, 1'b0);
            default: new_event = 1'b0;
         endcase
         tick();
      end
      chk("burst_nbytes", got_b.size(), 12);
      chk("burst_span", last - first + 1, 12);
      chk("burst_peak", peak, 2);
      for (int k = 0; k < 12; k++)
         chk("burst_byte", (k < got_b.size()) ? got_b[k] : 8'hxx, burst_exp[k]);

      // overflow: one record parked in the serializer, then 18 strobes while stalled
      tx_ready = 1'b0;
      set_ev(8'hA5, 7'h12, 16'h1234, 1'b1);
      tick();
      new_event = 1'b0;
      tick();
      chk("ovf_pre_valid", tx_valid, 1);
      chk("ovf_pre_count", fifo_count, 0);
      for (int i = 0; i < 18; i++) begin
         set_ev(8'(i), 7'h2A, 16'h1000 + 16'(i), 1'b0);
         tick();
      end
      new_event = 1'b0;
      chk("ovf_count", fifo_count, 16);
      chk("ovf_flag", overflow, 1);
      chk("ovf_data_held", tx_data, 8'hD2);
`ifdef DVS_EVENT_DROP_CNT_EN
      chk("ovf_drop", drop_count, 2);
`endif
      tx_ready = 1'b1;
      nb = 0; acc = '0;
      for (cyc = 0; cyc < 200 && got_w.size() < 17; cyc++) begin
         if (tx_valid) begin
            acc = {acc[23:0], tx_data};
            nb++;
            if (nb % 4 == 0) got_w.push_back(acc);
         end
         tick();
      end
      chk("ovf_nwords", got_w.size(), 17);
      chk("ovf_word0", (got_w.size() > 0) ? got_w[0] : 32'hx, 32'hD2921234);
      for (int k = 1; k < 17; k++) begin
         expw = {1'b0, 8'(k - 1), 7'h2A, 16'h1000 + 16'(k - 1)};
         chk("ovf_word", (k < got_w.size()) ? got_w[k] : 32'hx, expw);
      end
      chk("ovf_drain_valid", tx_valid, 0);
      chk("ovf_drain_count", fifo_count, 0);

      // clear, refill, then clear racing a drop
      overflow_clr = 1'b1;
      tick();
      overflow_clr = 1'b0;
      chk("clr_flag", overflow, 0);
`ifdef DVS_EVENT_DROP_CNT_EN
      chk("clr_drop", drop_count, 0);
`endif
      tx_ready = 1'b0;
      for (int i = 0; i < 17; i++) begin
         set_ev(8'h40 + 8'(i), 7'h01, 16'(i), 1'b1);
         tick();
      end
      new_event = 1'b0;
      chk("race_pre_count", fifo_count, 16);
      chk("race_pre_flag", overflow, 0);
      set_ev(8'h77, 7'h77, 16'h7777, 1'b1);
      overflow_clr = 1'b1;
      tick();
      new_event = 1'b0;
      overflow_clr = 1'b0;
      chk("race_flag", overflow, 1);
      chk("race_count", fifo_count, 16);
`ifdef DVS_EVENT_DROP_CNT_EN
      chk("race_drop", drop_count, 1);
`endif
      tx_ready = 1'b1;
      for (cyc = 0; cyc < 200 && (tx_valid || fifo_count != 0); cyc++) tick();
      chk("race_drain", {tx_valid, fifo_count}, 0);

      // reset after two bytes of a record with another record queued
      set_ev(8'hA5, 7'h12, 16'h1234, 1'b1);
      tick();
      set_ev(8'h3C, 7'h55, 16'hBEEF, 1'b0);
      tick();
      new_event = 1'b0;
      chk("mid_b0", tx_data, 8'hD2);
      tick();
      tick();
      chk("mid_b2", tx_data, 8'h12);
      chk("mid_count", fifo_count, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", tx_valid, 0);
      chk("mid_rst_count", fifo_count, 0);
      chk("mid_rst_data", tx_data, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("post_rst_quiet", tx_valid, 0);
      end
      set_ev(8'hFF, 7'h7F, 16'hFFFF, 1'b1);
      tick();
      new_event = 1'b0;
      tick();
      chk("post_rst_valid", tx_valid, 1);
      chk("post_rst_b0", tx_data, 8'hFF);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("post_rst_bn", tx_data, 8'hFF);
      end
      tick();
      chk("post_rst_idle", tx_valid, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/dvs_event_streamer.md
DVS_EVENT_STREAMER -- requirements
Module: dvs_event_streamer

Interface
REQ-001 SHALL have parameter X_BITS, default DVS_X_ADDR_BITS, event X address width.
REQ-002 SHALL have parameter Y_BITS, default DVS_Y_ADDR_BITS, event Y address width.
REQ-003 SHALL have parameter TS_BITS, default TIMESTAMP_US_BITS, event timestamp width (us).
REQ-004 SHALL have parameter FIFO_DEPTH, default 16, event FIFO entries, power of 2, at least 2.
REQ-005 SHALL have port clk, input, 1, system clock; reset rst_n, asynchronous, active-low; clock clk.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have ports event_x/event_y/event_timestamp/event_polarity, inputs, X_BITS/Y_BITS/TS_BITS/1, event fields from the AER receiver.
REQ-008 SHALL have port new_event, input, 1, single-cycle strobe qualifying the event fields.
REQ-009 SHALL have ports tx_data (output, 8), tx_valid (output, 1) and tx_ready (input, 1), forming the byte stream toward RAVENS.
REQ-010 SHALL have port fifo_count, output, clog2(FIFO_DEPTH)+1, number of stored events.
REQ-011 SHALL have ports overflow (output, 1, sticky drop flag) and overflow_clr (input, 1, clears overflow).

Function
REQ-012 Record SHALL be {zero pad, polarity, x, y, timestamp}, REC_BITS=1+X_BITS+Y_BITS+TS_BITS, padded at the MSB to NBYTES=ceil(REC_BITS/8) bytes.
REQ-013 On a clk edge with new_event=1 and pre-edge fifo_count<FIFO_DEPTH, the record SHALL be written to the FIFO.
REQ-014 On a clk edge with new_event=1 and pre-edge fifo_count==FIFO_DEPTH, the event SHALL be dropped and overflow set, even if a pop occurs on the same edge.
REQ-015 A simultaneous push and pop SHALL leave fifo_count unchanged; read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-016 Serializer FSM SHALL have two states: IDLE and SEND.
REQ-017 In IDLE with fifo_count>0, the next edge SHALL pop the head into the shift register, set byte index 0 and enter SEND.
REQ-018 In SEND, tx_valid SHALL be 1 and tx_data SHALL be byte[NBYTES-1-index], most significant byte first.
REQ-019 tx_data SHALL hold stable while tx_valid=1 and tx_ready=0.
REQ-020 On an edge with tx_valid=1 and tx_ready=1 and index<NBYTES-1, the index SHALL increment.
REQ-021 On the last-byte handshake, the FSM SHALL pop the next record and stay in SEND if fifo_count>0, giving back-to-back records with no bubble; otherwise it SHALL return to IDLE.
REQ-022 First-byte latency SHALL be 2 edges: new_event sampled at edge E0, tx_valid=1 after edge E1.
REQ-023 tx_valid SHALL be 0 in IDLE.
REQ-024 overflow_clr and a drop on the same edge SHALL leave overflow=1 (set wins).

Reset
REQ-025 On rst_n=0, FSM=IDLE, pointers=0, fifo_count=0, tx_valid=0, tx_data=0, overflow=0 and drop_count=0, asynchronously.
REQ-026 Reset asserted mid-record SHALL discard the partial record and all FIFO contents; after release, no stale bytes SHALL be emitted.

Configuration
REQ-027 With DVS_EVENT_DROP_CNT_EN defined, the block SHALL expose output drop_count[15:0], incremented per dropped event, saturating at 16'hFFFF and cleared by overflow_clr; clear plus drop on the same edge SHALL yield 1.
REQ-028 Without DVS_EVENT_DROP_CNT_EN, the drop_count port and counter SHALL not exist; all other behaviour is unchanged.

Verification (bench: X_BITS=8, Y_BITS=7, TS_BITS=16, REC_BITS=32, NBYTES=4, FIFO_DEPTH=16)
REQ-029 Single event: x=8'hA5, y=7'h12, ts=16'h1234, pol=1 with tx_ready=1 -> tx_valid rises 2 edges after the strobe; bytes are 8'hD2, 8'h92, 8'h12, 8'h34.
REQ-030 Backpressure: hold tx_ready=0 for 5 cycles mid-record -> tx_data stays stable; no byte is lost or duplicated.
REQ-031 Burst: 3 strobes on consecutive cycles with tx_ready=1 -> 12 consecutive valid bytes with no gap; fifo_count peaks at 2.
REQ-032 Overflow: tx_ready=0 and 18 strobes -> fifo_count=16, overflow=1, drop_count=2 (macro on); the first 16 records are emitted in order once tx_ready=1.
REQ-033 Clear race: overflow_clr and a drop on the same edge -> overflow=1, drop_count=1.
REQ-034 Reset asserted after 2 bytes of a record -> tx_valid=0 and fifo_count=0 immediately; no output until a new strobe arrives.
